// File: rtl/hyperram_avm_arbit.sv
// Two-client Avalon-MM arbiter in front of the HyperRAM controller.
// Grants are round-robin, and each grant is held for one complete burst.
// Command and data paths are combinational muxes, so they add no latency.
// Read responses are steered only to the client that owns the current burst.
module hyperram_avm_arbit #(
    parameter int G_ADDR_W = 32,
    parameter int G_DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  s0_avm_write_i,
    input  logic                  s0_avm_read_i,
    input  logic [G_ADDR_W-1:0]   s0_avm_address_i,
    input  logic [G_DATA_W-1:0]   s0_avm_writedata_i,
    input  logic [G_DATA_W/8-1:0] s0_avm_byteenable_i,
    input  logic [7:0]            s0_avm_burstcount_i,
    output logic [G_DATA_W-1:0]   s0_avm_readdata_o,
    output logic                  s0_avm_readdatavalid_o,
    output logic                  s0_avm_waitrequest_o,

    input  logic                  s1_avm_write_i,
    input  logic                  s1_avm_read_i,
    input  logic [G_ADDR_W-1:0]   s1_avm_address_i,
    input  logic [G_DATA_W-1:0]   s1_avm_writedata_i,
    input  logic [G_DATA_W/8-1:0] s1_avm_byteenable_i,
    input  logic [7:0]            s1_avm_burstcount_i,
    output logic [G_DATA_W-1:0]   s1_avm_readdata_o,
    output logic                  s1_avm_readdatavalid_o,
    output logic                  s1_avm_waitrequest_o,

    output logic                  m_avm_write_o,
    output logic                  m_avm_read_o,
    output logic [G_ADDR_W-1:0]   m_avm_address_o,
    output logic [G_DATA_W-1:0]   m_avm_writedata_o,
    output logic [G_DATA_W/8-1:0] m_avm_byteenable_o,
    output logic [7:0]            m_avm_burstcount_o,
    input  logic [G_DATA_W-1:0]   m_avm_readdata_i,
    input  logic                  m_avm_readdatavalid_i,
    input  logic                  m_avm_waitrequest_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    logic [7:0] cnt;
    logic       cmd_done;

    logic       req0;
    logic       req1;
    logic       arb_grant;
    logic       arb_write;
    logic       sel_write;
    logic       sel_read;
    logic [7:0] sel_burst;
    logic [7:0] burst_eff;
    logic       in_write;
    logic       in_read;
    logic       active;
    logic       beat_acc;
    logic       cmd_acc;
    logic       rdv_fwd;

    // Arbitration decision: a tie goes to the client that was not served last.
    always_comb begin
        req0      = s0_avm_write_i | s0_avm_read_i;
        req1      = s1_avm_write_i | s1_avm_read_i;
        arb_grant = (req0 && req1) ? ~last_grant : req1;
        arb_write = arb_grant ? s1_avm_write_i : s0_avm_write_i;
    end

    // Command/data mux toward the controller, steered by the held grant.
    always_comb begin
        sel_write          = grant ? s1_avm_write_i      : s0_avm_write_i;
        sel_read           = grant ? s1_avm_read_i       : s0_avm_read_i;
        sel_burst          = grant ? s1_avm_burstcount_i : s0_avm_burstcount_i;
        m_avm_address_o    = grant ? s1_avm_address_i    : s0_avm_address_i;
        m_avm_writedata_o  = grant ? s1_avm_writedata_i  : s0_avm_writedata_i;
        m_avm_byteenable_o = grant ? s1_avm_byteenable_i : s0_avm_byteenable_i;
        m_avm_burstcount_o = sel_burst;
        // A zero burstcount is illegal; count it as a single beat.
        burst_eff          = (sel_burst == 8'd0) ? 8'd1 : sel_burst;

        // Reset forces the command and handshake outputs idle immediately.
        in_write      = !rst_i && (state == ST_WRITE);
        in_read       = !rst_i && (state == ST_READ);
        active        = in_write || in_read;
        m_avm_write_o = in_write && sel_write;
        // A read command is issued once; later cycles only collect data.
        m_avm_read_o  = in_read && sel_read && !cmd_done;
        beat_acc      = m_avm_write_o && !m_avm_waitrequest_i;
        cmd_acc       = m_avm_read_o && !m_avm_waitrequest_i;
        // Responses outside a read burst are dropped.
        rdv_fwd       = in_read && m_avm_readdatavalid_i;
    end

    // Client-side response and handshake steering.
    always_comb begin
        s0_avm_readdata_o      = m_avm_readdata_i;
        s1_avm_readdata_o      = m_avm_readdata_i;
        s0_avm_readdatavalid_o = rdv_fwd && !grant;
        s1_avm_readdatavalid_o = rdv_fwd && grant;
        s0_avm_waitrequest_o   = (active && !grant) ? m_avm_waitrequest_i : 1'b1;
        s1_avm_waitrequest_o   = (active && grant)  ? m_avm_waitrequest_i : 1'b1;
    end

    // Burst FSM: arbitrate, then track beats until the burst completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 8'd0;
            cmd_done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt      <= 8'd0;
                    cmd_done <= 1'b0;
                    if (req0 || req1) begin
                        grant <= arb_grant;
                        state <= arb_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    // cmd_done marks that the first beat has been taken.
                    if (beat_acc) begin
                        if (!cmd_done) begin
                            if (burst_eff == 8'd1) begin
                                state      <= ST_IDLE;
                                last_grant <= grant;
                                cnt        <= 8'd0;
                            end else begin
                                cnt      <= burst_eff - 8'd1;
                                cmd_done <= 1'b1;
                            end
                        end else if (cnt <= 8'd1) begin
                            state      <= ST_IDLE;
                            last_grant <= grant;
                            cnt        <= 8'd0;
                            cmd_done   <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (cmd_acc) begin
                        cnt      <= burst_eff;
                        cmd_done <= 1'b1;
                    end else if (cmd_done && m_avm_readdatavalid_i) begin
                        if (cnt <= 8'd1) begin
                            state      <= ST_IDLE;
                            last_grant <= grant;
                            cnt        <= 8'd0;
                            cmd_done   <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= 8'd0;
                    cmd_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_avm_arbit.sv
// Directed bench for the two-client HyperRAM Avalon-MM arbiter.
module tb_hyperram_avm_arbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_write, s0_read, s1_write, s1_read;
    logic [31:0] s0_addr, s1_addr;
    logic [15:0] s0_wdata, s1_wdata;
    logic [1:0]  s0_be, s1_be;
    logic [7:0]  s0_bc, s1_bc;
    logic [15:0] s0_rdata, s1_rdata;
    logic        s0_rdv, s1_rdv, s0_wait, s1_wait;
    logic        m_write, m_read;
    logic [31:0] m_addr;
    logic [15:0] m_wdata;
    logic [1:0]  m_be;
    logic [7:0]  m_bc;
    logic [15:0] m_rdata;
    logic        m_rdv, m_wait;

    int n_tests = 0;
    int n_fail  = 0;

    hyperram_avm_arbit #(.G_ADDR_W(32), .G_DATA_W(16)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .s0_avm_write_i        (s0_write),
        .s0_avm_read_i         (s0_read),
        .s0_avm_address_i      (s0_addr),
        .s0_avm_writedata_i    (s0_wdata),
        .s0_avm_byteenable_i   (s0_be),
        .s0_avm_burstcount_i   (s0_bc),
        .s0_avm_readdata_o     (s0_rdata),
        .s0_avm_readdatavalid_o(s0_rdv),
        .s0_avm_waitrequest_o  (s0_wait),
        .s1_avm_write_i        (s1_write),
        .s1_avm_read_i         (s1_read),
        .s1_avm_address_i      (s1_addr),
        .s1_avm_writedata_i    (s1_wdata),
        .s1_avm_byteenable_i   (s1_be),
        .s1_avm_burstcount_i   (s1_bc),
        .s1_avm_readdata_o     (s1_rdata),
        .s1_avm_readdatavalid_o(s1_rdv),
        .s1_avm_waitrequest_o  (s1_wait),
        .m_avm_write_o         (m_write),
        .m_avm_read_o          (m_read),
        .m_avm_address_o       (m_addr),
        .m_avm_writedata_o     (m_wdata),
        .m_avm_byteenable_o    (m_be),
        .m_avm_burstcount_o    (m_bc),
        .m_avm_readdata_i      (m_rdata),
        .m_avm_readdatavalid_i (m_rdv),
        .m_avm_waitrequest_i   (m_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_write = 0; s0_read = 0; s1_write = 0; s1_read = 0;
        s0_addr = 0; s1_addr = 0; s0_wdata = 0; s1_wdata = 0;
        s0_be = 2'b11; s1_be = 2'b11; s0_bc = 8'd1; s1_bc = 8'd1;
        m_rdata = 0; m_rdv = 0; m_wait = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Deliver n read beats and check they reach only client 'who'.
    task automatic resp(input string tag, input int who, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            m_rdv   = 1;
            m_rdata = base + 16'(k);
            #1;
            check({tag, "_rdv_own"},   who ? s1_rdv : s0_rdv, 1);
            check({tag, "_rdv_other"}, who ? s0_rdv : s1_rdv, 0);
            check({tag, "_rdata"},     who ? s1_rdata : s0_rdata, 32'(base + 16'(k)));
            tick();
        end
        m_rdv = 0;
    endtask

    initial begin
        int sent, mbeats, stall_bad, wdata_bad;
        logic acc;

        idle_inputs();
        rst = 1;
        s0_read = 1;
        tick();
        tick();
        check("rst_m_write", m_write, 0);
        check("rst_m_read",  m_read, 0);
        check("rst_s0_wait", s0_wait, 1);
        check("rst_s1_wait", s1_wait, 1);
        m_rdv = 1;
        #1;
        check("rst_s0_rdv", s0_rdv, 0);
        check("rst_s1_rdv", s1_rdv, 0);
        m_rdv = 0;
        s0_read = 0;
        rst = 0;
        tick();

        // 1: single write from s0
        s0_write = 1; s0_addr = 32'h10; s0_wdata = 16'h1234; s0_be = 2'b10; s0_bc = 8'd1;
        #1;
        check("t1_arb_cycle_write", m_write, 0);
        check("t1_arb_cycle_wait", s0_wait, 1);
        tick();
        check("t1_m_write", m_write, 1);
        check("t1_m_addr",  m_addr, 32'h10);
        check("t1_m_wdata", m_wdata, 32'h1234);
        check("t1_m_be",    m_be, 2'b10);
        check("t1_s0_wait", s0_wait, 0);
        check("t1_s1_wait", s1_wait, 1);
        tick();
        s0_write = 0;
        #1;
        check("t1_idle_write", m_write, 0);
        check("t1_idle_wait", s0_wait, 1);

        // 2 + 6: simultaneous reads from reset, round-robin, register-space address
        idle_inputs();
        do_reset();
        s0_read = 1; s0_addr = 32'h100; s0_bc = 8'd4;
        s1_read = 1; s1_addr = 32'h8000_0200; s1_bc = 8'd4;
        #1;
        check("t2_arb_read", m_read, 0);
        tick();
        check("t2_g0_read", m_read, 1);
        check("t2_g0_addr", m_addr, 32'h100);
        check("t2_g0_s0_wait", s0_wait, 0);
        check("t2_g0_s1_wait", s1_wait, 1);
        tick();
        s0_read = 0;
        #1;
        check("t2_read_once", m_read, 0);
        resp("t2_s0", 0, 4, 16'hA000);
        m_rdv = 1;
        #1;
        check("t2_idle_m_read", m_read, 0);
        check("t2_stray_s0", s0_rdv, 0);
        check("t2_stray_s1", s1_rdv, 0);
        m_rdv = 0;
        s0_read = 1;
        tick();
        check("t2_g1_read", m_read, 1);
        check("t6_addr_bit31", m_addr, 32'h8000_0200);
        check("t2_g1_s1_wait", s1_wait, 0);
        check("t2_g1_s0_wait", s0_wait, 1);
        tick();
        s1_read = 0;
        resp("t2_s1", 1, 4, 16'hC000);
        tick();
        check("t2_alt_addr", m_addr, 32'h100);
        check("t2_alt_s0_wait", s0_wait, 0);
        tick();
        s0_read = 0;
        resp("t2_s0b", 0, 4, 16'hD000);

        // 3: s1 write burst 8 with toggling waitrequest, s0 stalled
        s1_write = 1; s1_addr = 32'h40; s1_wdata = 16'h5000; s1_bc = 8'd8;
        tick();
        s0_read = 1; s0_addr = 32'h300; s0_bc = 8'd2;
        sent = 0; mbeats = 0; stall_bad = 0; wdata_bad = 0;
        for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
            m_wait = (cyc % 2 == 0);
            #1;
            if (s0_wait !== 1'b1) stall_bad++;
            if (m_write && !m_wait) begin
                mbeats++;
                if (m_wdata !== 16'h5000 + 16'(sent)) wdata_bad++;
            end
            acc = s1_write && !s1_wait;
            tick();
            if (acc) begin
                sent++;
                s1_wdata = 16'h5000 + 16'(sent);
                if (sent == 8) s1_write = 0;
            end
        end
        m_wait = 0;
        check("t3_beats", mbeats, 8);
        check("t3_s0_stall_bad", stall_bad, 0);
        check("t3_wdata_bad", wdata_bad, 0);
        #1;
        check("t3_idle_write", m_write, 0);

        // 4: s0 read burst 2 with s1 write pending
        s1_write = 1; s1_addr = 32'h50; s1_wdata = 16'h7777; s1_bc = 8'd1;
        tick();
        m_wait = 1;
        #1;
        check("t4_read_stalled", m_read, 1);
        check("t4_s1_wait_a", s1_wait, 1);
        tick();
        m_wait = 0;
        #1;
        check("t4_read_held", m_read, 1);
        tick();
        s0_read = 0;
        #1;
        check("t4_read_dropped", m_read, 0);
        m_rdv = 1; m_rdata = 16'hB000;
        #1;
        check("t4_rdv1_s0", s0_rdv, 1);
        check("t4_rdv1_s1_wait", s1_wait, 1);
        check("t4_rdv1_m_write", m_write, 0);
        tick();
        m_rdata = 16'hB001;
        #1;
        check("t4_rdv2_s0", s0_rdv, 1);
        check("t4_rdv2_s1_wait", s1_wait, 1);
        tick();
        m_rdv = 0;
        #1;
        check("t4_gap_write", m_write, 0);
        check("t4_gap_s1_wait", s1_wait, 1);
        tick();
        check("t4_s1_write", m_write, 1);
        check("t4_s1_wdata", m_wdata, 32'h7777);
        check("t4_s1_wait", s1_wait, 0);
        tick();
        s1_write = 0;
        #1;
        check("t4_done_write", m_write, 0);

        // 5: reset in the middle of a read burst of 16
        s0_read = 1; s0_addr = 32'h400; s0_bc = 8'd16;
        tick();
        check("t5_m_read", m_read, 1);
        tick();
        s0_read = 0;
        resp("t5_s0", 0, 5, 16'hE000);
        rst = 1; m_rdv = 1;
        #1;
        check("t5_rst_s0_rdv", s0_rdv, 0);
        check("t5_rst_m_read", m_read, 0);
        check("t5_rst_s0_wait", s0_wait, 1);
        check("t5_rst_s1_wait", s1_wait, 1);
        tick();
        rst = 0;
        #1;
        check("t5_after_s0_rdv", s0_rdv, 0);
        check("t5_after_s1_rdv", s1_rdv, 0);
        check("t5_after_s0_wait", s0_wait, 1);
        tick();
        check("t5_stray_s0_rdv", s0_rdv, 0);
        m_rdv = 0;

        // burstcount 0 behaves as a single beat
        s0_write = 1; s0_addr = 32'h20; s0_wdata = 16'h0BC0; s0_bc = 8'd0;
        tick();
        check("bc0_write", m_write, 1);
        check("bc0_m_bc", m_bc, 0);
        tick();
        s0_write = 0;
        #1;
        check("bc0_done", m_write, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
